// File: rtl/control_decoder.sv
// Microinstruction decoder: splits a 16-bit microinstruction into bus source/destination strobes,
// ALU function bits and jump enables. All strobes are held inactive until reset release settles.
module control_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] uinstr,
    output logic        EO_bar,
    output logic        PO_bar,
    output logic        IOH_bar,
    output logic        IOL_bar,
    output logic        MO,
    output logic        DO,
    output logic        RT,
    output logic        PP,
    output logic        AI_bar,
    output logic        II_bar,
    output logic        MI,
    output logic        XI_bar,
    output logic        YI_bar,
    output logic        DI,
    output logic        JC,
    output logic        JZ,
    output logic        JGT,
    output logic        JLT,
    output logic [6:0]  ALU_flags
);

    typedef enum logic [2:0] {
        SrcPc    = 3'b000,
        SrcIrHi  = 3'b001,
        SrcIrLo  = 3'b010,
        SrcMem   = 3'b011,
        SrcNone0 = 3'b100,
        SrcNone1 = 3'b101,
        SrcDev   = 3'b110,
        SrcNone2 = 3'b111
    } src_sel_e;

    typedef enum logic [2:0] {
        DstNone0 = 3'b000,
        DstA     = 3'b001,
        DstIr    = 3'b010,
        DstMem   = 3'b011,
        DstX     = 3'b100,
        DstY     = 3'b101,
        DstDev   = 3'b110,
        DstNone1 = 3'b111
    } dst_sel_e;

    logic en1_q, en1_d;
    logic en2_q, en2_d;

    src_sel_e src_sel;
    dst_sel_e dst_sel;
    logic     alu_drives_bus;

    // Reserved bit; named so lint treats it as intentionally unused.
    logic unused_rsvd;
    assign unused_rsvd = uinstr[0];

    // Two-stage reset-release synchroniser gating every strobe.
    always_comb begin
        en1_d = 1'b1;
        en2_d = en1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en1_q <= 1'b0;
            en2_q <= 1'b0;
        end else begin
            en1_q <= en1_d;
            en2_q <= en2_d;
        end
    end

    assign src_sel        = src_sel_e'(uinstr[14:12]);
    assign dst_sel        = dst_sel_e'(uinstr[7:5]);
    assign alu_drives_bus = ~uinstr[15];

    always_comb begin
        EO_bar    = 1'b1;
        PO_bar    = 1'b1;
        IOH_bar   = 1'b1;
        IOL_bar   = 1'b1;
        MO        = 1'b0;
        DO        = 1'b0;
        RT        = 1'b0;
        PP        = 1'b0;
        AI_bar    = 1'b1;
        II_bar    = 1'b1;
        MI        = 1'b0;
        XI_bar    = 1'b1;
        YI_bar    = 1'b1;
        DI        = 1'b0;
        JC        = 1'b0;
        JZ        = 1'b0;
        JGT       = 1'b0;
        JLT       = 1'b0;
        ALU_flags = 7'd0;

        if (en2_q) begin
            ALU_flags = uinstr[14:8];
            JZ        = uinstr[4];
            JGT       = uinstr[3];
            JLT       = uinstr[2];
            JC        = uinstr[1];

            // Bits 14:10 double as ALU function and source select; only one interpretation drives.
            if (alu_drives_bus) begin
                EO_bar = 1'b0;
            end else begin
                RT = uinstr[11];
                PP = uinstr[10];
                case (src_sel)
                    SrcPc:   PO_bar  = 1'b0;
                    SrcIrHi: IOH_bar = 1'b0;
                    SrcIrLo: IOL_bar = 1'b0;
                    SrcMem:  MO      = 1'b1;
                    SrcDev:  DO      = 1'b1;
                    default: ;
                endcase
            end

            case (dst_sel)
                DstA:    AI_bar = 1'b0;
                DstIr:   II_bar = 1'b0;
                DstMem:  MI     = 1'b1;
                DstX:    XI_bar = 1'b0;
                DstY:    YI_bar = 1'b0;
                DstDev:  DI     = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_decoder.sv
// Scoreboard bench for control_decoder: driver pushes reference-model expectations, a monitor
// pops and compares against the combinational outputs on the falling clock edge.
module tb_control_decoder;

    logic        clk;
    logic        rst_n;
    logic [15:0] uinstr;
    logic        EO_bar, PO_bar, IOH_bar, IOL_bar, MO, DO, RT, PP;
    logic        AI_bar, II_bar, MI, XI_bar, YI_bar, DI, JC, JZ, JGT, JLT;
    logic [6:0]  ALU_flags;

    control_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uinstr    (uinstr),
        .EO_bar    (EO_bar),
        .PO_bar    (PO_bar),
        .IOH_bar   (IOH_bar),
        .IOL_bar   (IOL_bar),
        .MO        (MO),
        .DO        (DO),
        .RT        (RT),
        .PP        (PP),
        .AI_bar    (AI_bar),
        .II_bar    (II_bar),
        .MI        (MI),
        .XI_bar    (XI_bar),
        .YI_bar    (YI_bar),
        .DI        (DI),
        .JC        (JC),
        .JZ        (JZ),
        .JGT       (JGT),
        .JLT       (JLT),
        .ALU_flags (ALU_flags)
    );

    // Strobe positions in the 18-bit "asserted" vector (MSB first, same order as dut_vec).
    localparam int I_EO = 17, I_PO = 16, I_IOH = 15, I_IOL = 14, I_MO = 13, I_DO = 12;
    localparam int I_RT = 11, I_PP = 10, I_AI = 9, I_II = 8, I_MI = 7, I_XI = 6;
    localparam int I_YI = 5, I_DI = 4, I_JC = 3, I_JZ = 2, I_JGT = 1, I_JLT = 0;

    localparam logic [17:0] BAR_MASK = (18'd1 << I_EO) | (18'd1 << I_PO) | (18'd1 << I_IOH) |
                                       (18'd1 << I_IOL) | (18'd1 << I_AI) | (18'd1 << I_II) |
                                       (18'd1 << I_XI) | (18'd1 << I_YI);

    typedef struct packed {
        logic [15:0] u;
        logic [24:0] exp;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          edges  = 0;
    logic [24:0] dut_vec;

    assign dut_vec = {EO_bar, PO_bar, IOH_bar, IOL_bar, MO, DO, RT, PP, AI_bar, II_bar, MI,
                      XI_bar, YI_bar, DI, JC, JZ, JGT, JLT, ALU_flags};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges seen since the last reset assertion (saturating at 2).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else if (edges < 2) edges <= edges + 1;
    end

    function automatic logic [24:0] model(input logic [15:0] u, input bit en);
        int          src_tbl[8];
        int          dst_tbl[8];
        logic [17:0] act;
        int          s;
        int          d;
        src_tbl = '{I_PO, I_IOH, I_IOL, I_MO, -1, -1, I_DO, -1};
        dst_tbl = '{-1, I_AI, I_II, I_MI, I_XI, I_YI, I_DI, -1};
        act = '0;
        if (!en) return {BAR_MASK, 7'd0};
        if (u[15] == 1'b0) begin
            act[I_EO] = 1'b1;
        end else begin
            s = src_tbl[int'(u[14:12])];
            if (s >= 0) act[s] = 1'b1;
            act[I_RT] = u[11];
            act[I_PP] = u[10];
        end
        d = dst_tbl[int'(u[7:5])];
        if (d >= 0) act[d] = 1'b1;
        act[I_JZ]  = u[4];
        act[I_JGT] = u[3];
        act[I_JLT] = u[2];
        act[I_JC]  = u[1];
        return {act ^ BAR_MASK, u[14:8]};
    endfunction

    task automatic step(input logic [15:0] u);
        sb_entry_t e;
        @(posedge clk);
        #2;
        uinstr = u;
        e.u    = u;
        e.exp  = model(u, edges >= 2);
        sb_q.push_back(e);
    endtask

    // Assert reset mid-operation; outputs must drop to idle without waiting for a clock.
    task automatic step_reset(input logic [15:0] u);
        sb_entry_t e;
        @(posedge clk);
        #2;
        uinstr = u;
        rst_n  = 1'b0;
        e.u    = u;
        e.exp  = model(u, 1'b0);
        sb_q.push_back(e);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: outputs are combinational, so they are valid one half-cycle after the driver.
    initial begin
        sb_entry_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (dut_vec !== e.exp) begin
                    errors++;
                    $display("FAIL decode uinstr=%h got=%b exp=%b", e.u, dut_vec, e.exp);
                end
            end
        end
    end

    initial begin
        logic [15:0] directed[$];
        rst_n  = 1'b0;
        uinstr = 16'h0000;

        for (int i = 0; i < 3; i++) step(16'($urandom));
        release_reset();
        step(16'h8000);  // first edge after release: still gated
        step(16'h8000);  // second edge: enabled

        directed = '{16'h8000, 16'h3E20, 16'hB4A0, 16'h80C0, 16'h80E0, 16'h9000, 16'hA000,
                     16'hE000, 16'h8800, 16'h8400, 16'h8002, 16'h8004, 16'h8008, 16'h8010,
                     16'h8001, 16'hC000, 16'hD000, 16'hF000, 16'h80A0, 16'h8080, 16'h8060,
                     16'h8040, 16'h8020, 16'h7FFF, 16'hFFFF, 16'h0000};
        foreach (directed[i]) step(directed[i]);

        for (int i = 0; i < 300; i++) step(16'($urandom));

        step_reset(16'($urandom));
        step(16'($urandom));
        release_reset();
        step(16'h3E20);
        step(16'hB4A0);
        for (int i = 0; i < 40; i++) step(16'($urandom));

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
